// File: rtl/cmd_engine.sv
// Command engine: parses opcode/argument bytes from the RX FIFO, drives PWM
// channels, the shutter and ADC requests, and queues replies into the TX FIFO.
module cmd_engine #(
    parameter int N_PWM          = 4,
    parameter int PWM_WIDTH      = 8,
    parameter int ADC_BYTES      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_rdata,
    input  logic                   rx_rempty,
    output logic                   rx_rinc,
    output logic [7:0]             tx_wdata,
    output logic                   tx_winc,
    input  logic                   tx_wfull,
    output logic                   adc_sample,
    input  logic                   adc_busy,
    input  logic [8*ADC_BYTES-1:0] adc_data,
    output logic [2:0]             adc_channel,
    output logic [N_PWM-1:0]       pwm_out,
    output logic                   shutter_open
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IDX_W = (ADC_BYTES > 2) ? $clog2(ADC_BYTES) : 1;

    localparam logic [7:0] OP_GET_ADC    = 8'h01;
    localparam logic [7:0] OP_PWM_SET    = 8'h10;
    localparam logic [7:0] OP_PWM_EN     = 8'h11;
    localparam logic [7:0] OP_SHUT_OPEN  = 8'h20;
    localparam logic [7:0] OP_SHUT_CLOSE = 8'h21;
    localparam logic [7:0] OP_STATUS     = 8'h30;

    localparam logic [7:0] ERR_OPCODE  = 8'h01;
    localparam logic [7:0] ERR_TIMEOUT = 8'h02;
    localparam logic [7:0] ERR_CHANNEL = 8'h03;

    typedef enum logic [3:0] {
        IDLE, RD_OP, EVAL_OP, WAIT_ARG, RD_ARG, EVAL_ARG,
        ADC_START, ADC_WAIT, TX_ADC, TX_STATUS
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             opcode_q, opcode_d;
    logic                   argIdx_q, argIdx_d;
    logic [7:0]             pwmChan_q, pwmChan_d;
    logic [TO_W-1:0]        timer_q, timer_d;
    logic [IDX_W-1:0]       byteIdx_q, byteIdx_d;
    logic [8*ADC_BYTES-1:0] adcBuf_q, adcBuf_d;
    logic [7:0]             errCount_q, errCount_d;
    logic [7:0]             lastErr_q, lastErr_d;
    logic                   shutter_q, shutter_d;
    logic [2:0]             adcChan_q, adcChan_d;
    logic [N_PWM-1:0]       enMask_q, enMask_d;
    logic [PWM_WIDTH-1:0]   shadow_q [N_PWM];
    logic [PWM_WIDTH-1:0]   shadow_d [N_PWM];
    logic [PWM_WIDTH-1:0]   duty_q   [N_PWM];
    logic [PWM_WIDTH-1:0]   cnt_q;
    logic [N_PWM-1:0]       pwm_q;
    logic                   errSet;
    logic [7:0]             errCode;

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        argIdx_d   = argIdx_q;
        pwmChan_d  = pwmChan_q;
        timer_d    = timer_q;
        byteIdx_d  = byteIdx_q;
        adcBuf_d   = adcBuf_q;
        errCount_d = errCount_q;
        lastErr_d  = lastErr_q;
        shutter_d  = shutter_q;
        adcChan_d  = adcChan_q;
        enMask_d   = enMask_q;
        shadow_d   = shadow_q;
        errSet     = 1'b0;
        errCode    = 8'h00;
        rx_rinc    = 1'b0;
        tx_winc    = 1'b0;
        tx_wdata   = 8'h00;
        adc_sample = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_rempty) state_d = RD_OP;
            end
            RD_OP: begin
                rx_rinc = 1'b1;
                state_d = EVAL_OP;
            end
            EVAL_OP: begin
                opcode_d  = rx_rdata;
                argIdx_d  = 1'b0;
                timer_d   = '0;
                byteIdx_d = '0;
                state_d   = IDLE;
                case (rx_rdata)
                    OP_GET_ADC, OP_PWM_SET, OP_PWM_EN: state_d = WAIT_ARG;
                    OP_SHUT_OPEN:  shutter_d = 1'b1;
                    OP_SHUT_CLOSE: shutter_d = 1'b0;
                    OP_STATUS:     state_d = TX_STATUS;
                    default: begin
                        errSet  = 1'b1;
                        errCode = ERR_OPCODE;
                    end
                endcase
            end
            WAIT_ARG: begin
                if (!rx_rempty) begin
                    state_d = RD_ARG;
                end else if (timer_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    errSet  = 1'b1;
                    errCode = ERR_TIMEOUT;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
            end
            RD_ARG: begin
                rx_rinc = 1'b1;
                state_d = EVAL_ARG;
            end
            EVAL_ARG: begin
                timer_d = '0;
                state_d = IDLE;
                case (opcode_q)
                    OP_GET_ADC: begin
                        adcChan_d = rx_rdata[2:0];
                        state_d   = ADC_START;
                    end
                    OP_PWM_EN: enMask_d = rx_rdata[N_PWM-1:0];
                    OP_PWM_SET: begin
                        // First argument is the channel; the duty byte is always consumed.
                        if (!argIdx_q) begin
                            pwmChan_d = rx_rdata;
                            argIdx_d  = 1'b1;
                            state_d   = WAIT_ARG;
                        end else if (pwmChan_q < 8'(N_PWM)) begin
                            for (int i = 0; i < N_PWM; i++) begin
                                if (pwmChan_q == 8'(i)) shadow_d[i] = PWM_WIDTH'(rx_rdata);
                            end
                        end else begin
                            errSet  = 1'b1;
                            errCode = ERR_CHANNEL;
                        end
                    end
                    default: ;
                endcase
            end
            ADC_START: begin
                adc_sample = 1'b1;
                if (adc_busy) state_d = ADC_WAIT;
            end
            ADC_WAIT: begin
                if (!adc_busy) begin
                    adcBuf_d  = adc_data;
                    byteIdx_d = '0;
                    state_d   = TX_ADC;
                end
            end
            TX_ADC: begin
                tx_wdata = adcBuf_q[8*byteIdx_q +: 8];
                if (!tx_wfull) begin
                    tx_winc = 1'b1;
                    if (byteIdx_q == IDX_W'(ADC_BYTES - 1)) state_d = IDLE;
                    else byteIdx_d = byteIdx_q + IDX_W'(1);
                end
            end
            TX_STATUS: begin
                tx_wdata = (byteIdx_q == '0) ? errCount_q : lastErr_q;
                if (!tx_wfull) begin
                    tx_winc = 1'b1;
                    if (byteIdx_q != '0) state_d = IDLE;
                    else byteIdx_d = byteIdx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (errSet) begin
            lastErr_d = errCode;
            if (errCount_q != 8'hFF) errCount_d = errCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            opcode_q   <= 8'h00;
            argIdx_q   <= 1'b0;
            pwmChan_q  <= 8'h00;
            timer_q    <= '0;
            byteIdx_q  <= '0;
            adcBuf_q   <= '0;
            errCount_q <= 8'h00;
            lastErr_q  <= 8'h00;
            shutter_q  <= 1'b0;
            adcChan_q  <= 3'd0;
            enMask_q   <= '0;
            for (int i = 0; i < N_PWM; i++) shadow_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            argIdx_q   <= argIdx_d;
            pwmChan_q  <= pwmChan_d;
            timer_q    <= timer_d;
            byteIdx_q  <= byteIdx_d;
            adcBuf_q   <= adcBuf_d;
            errCount_q <= errCount_d;
            lastErr_q  <= lastErr_d;
            shutter_q  <= shutter_d;
            adcChan_q  <= adcChan_d;
            enMask_q   <= enMask_d;
            shadow_q   <= shadow_d;
        end
    end

    // Active duty only reloads from the shadow at counter wrap, so no runt pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pwm_q <= '0;
            for (int i = 0; i < N_PWM; i++) duty_q[i] <= '0;
        end else begin
            cnt_q <= cnt_q + PWM_WIDTH'(1);
            for (int i = 0; i < N_PWM; i++) begin
                pwm_q[i] <= (cnt_q < duty_q[i]) && enMask_q[i];
                if (cnt_q == '1) duty_q[i] <= shadow_q[i];
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign shutter_open = shutter_q;
    assign adc_channel  = adcChan_q;

endmodule
